time_bcd_converter: RTL and testbench

Sequential binary-to-BCD stage between the `Digital_Clock` counter and `bcd_to_7seg_display`. It captures the binary time (`hours`, `minutes`, `seconds`) on request or on change. It converts all three fields to packed BCD with an iterative double-dabble engine, with optional 12-hour remapping. The 16-bit `hhmm_bcd` output drives the display's `bcd_data` input directly.

---
 rtl/clock_pkg.sv | 22 ++
 rtl/bcd_dabble_step.sv | 18 +
 rtl/time_bcd_converter.sv | 177 +++++++++++++++++
 tb/tb_time_bcd_converter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and limits for the binary-time to BCD conversion path.
package clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned HR_W        = 5;
  localparam int unsigned MS_W        = 6;
  localparam int unsigned MAX_HR      = 23;
  localparam int unsigned MAX_MS      = 59;
  localparam int unsigned DABBLE_ITER = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } conv_state_e;

  function automatic bcd_digit_t add3_ge5(input bcd_digit_t d);
    return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration for a two-digit BCD lane fed by a 6-bit binary operand.
module bcd_dabble_step
  import clock_pkg::*;
(
  input  logic [7:0]      bcd_i,
  input  logic [MS_W-1:0] bin_i,
  output logic [7:0]      bcd_o,
  output logic [MS_W-1:0] bin_o
);

  logic [7:0] adj;

  always_comb begin
    adj            = {add3_ge5(bcd_i[7:4]), add3_ge5(bcd_i[3:0])};
    {bcd_o, bin_o} = {adj[6:0], bin_i, 1'b0};
  end

endmodule

// File: rtl/time_bcd_converter.sv
// Captures hh:mm:ss, converts each field to packed BCD over ITER cycles, and
// presents {hh,mm} for the 7-segment driver with optional 12-hour remapping.
module time_bcd_converter
  import clock_pkg::*;
#(
  parameter bit          AUTO_START = 1'b0,
  parameter int unsigned ITER       = DABBLE_ITER
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [HR_W-1:0] hours,
  input  logic [MS_W-1:0] minutes,
  input  logic [MS_W-1:0] seconds,
  input  logic            mode_12h,
  input  logic            start,
  output logic [15:0]     hhmm_bcd,
  output logic [7:0]      sec_bcd,
  output logic            pm,
  output logic            busy,
  output logic            valid,
  output logic            err
);

  localparam int unsigned CNT_W = $clog2(ITER + 1);

  conv_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [7:0]       hr_bcd_q, hr_bcd_d, mn_bcd_q, mn_bcd_d, sc_bcd_q, sc_bcd_d;
  logic [MS_W-1:0]  hr_bin_q, hr_bin_d, mn_bin_q, mn_bin_d, sc_bin_q, sc_bin_d;
  logic [7:0]       hr_bcd_s, mn_bcd_s, sc_bcd_s;
  logic [MS_W-1:0]  hr_bin_s, mn_bin_s, sc_bin_s;

  logic             pm_cap_q, pm_cap_d;
  logic [15:0]      hhmm_q, hhmm_d;
  logic [7:0]       sec_q, sec_d;
  logic             pm_q, pm_d, valid_q, valid_d, err_q, err_d;

  logic [HR_W-1:0]  last_hr_q, last_hr_d;
  logic [MS_W-1:0]  last_mn_q, last_mn_d, last_sc_q, last_sc_d;

  logic [HR_W-1:0]  hr_conv;
  logic             pm_conv;
  logic             changed, in_range, trigger;

  bcd_dabble_step u_step_hr (.bcd_i(hr_bcd_q), .bin_i(hr_bin_q), .bcd_o(hr_bcd_s), .bin_o(hr_bin_s));
  bcd_dabble_step u_step_mn (.bcd_i(mn_bcd_q), .bin_i(mn_bin_q), .bcd_o(mn_bcd_s), .bin_o(mn_bin_s));
  bcd_dabble_step u_step_sc (.bcd_i(sc_bcd_q), .bin_i(sc_bin_q), .bcd_o(sc_bcd_s), .bin_o(sc_bin_s));

  assign changed  = (hours != last_hr_q) || (minutes != last_mn_q) || (seconds != last_sc_q);
  assign in_range = (hours <= HR_W'(MAX_HR)) && (minutes <= MS_W'(MAX_MS)) &&
                    (seconds <= MS_W'(MAX_MS));
  assign trigger  = start || (AUTO_START && changed);

  always_comb begin
    hr_conv = hours;
    pm_conv = 1'b0;
    if (mode_12h) begin
      if (hours == '0) begin
        hr_conv = HR_W'(12);
      end else if (hours >= HR_W'(12)) begin
        pm_conv = 1'b1;
        if (hours > HR_W'(12)) hr_conv = hours - HR_W'(12);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hr_bcd_d  = hr_bcd_q;
    mn_bcd_d  = mn_bcd_q;
    sc_bcd_d  = sc_bcd_q;
    hr_bin_d  = hr_bin_q;
    mn_bin_d  = mn_bin_q;
    sc_bin_d  = sc_bin_q;
    pm_cap_d  = pm_cap_q;
    hhmm_d    = hhmm_q;
    sec_d     = sec_q;
    pm_d      = pm_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    last_hr_d = last_hr_q;
    last_mn_d = last_mn_q;
    last_sc_d = last_sc_q;

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          // Operands are remembered even when rejected so auto-start does not loop on them.
          last_hr_d = hours;
          last_mn_d = minutes;
          last_sc_d = seconds;
          if (!in_range) begin
            err_d = 1'b1;
          end else begin
            hr_bcd_d = '0;
            mn_bcd_d = '0;
            sc_bcd_d = '0;
            hr_bin_d = MS_W'(hr_conv);
            mn_bin_d = minutes;
            sc_bin_d = seconds;
            pm_cap_d = pm_conv;
            cnt_d    = '0;
            state_d  = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        hr_bcd_d = hr_bcd_s;
        mn_bcd_d = mn_bcd_s;
        sc_bcd_d = sc_bcd_s;
        hr_bin_d = hr_bin_s;
        mn_bin_d = mn_bin_s;
        sc_bin_d = sc_bin_s;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        hhmm_d  = {hr_bcd_q, mn_bcd_q};
        sec_d   = sc_bcd_q;
        pm_d    = pm_cap_q;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hr_bcd_q  <= '0;
      mn_bcd_q  <= '0;
      sc_bcd_q  <= '0;
      hr_bin_q  <= '0;
      mn_bin_q  <= '0;
      sc_bin_q  <= '0;
      pm_cap_q  <= 1'b0;
      hhmm_q    <= '0;
      sec_q     <= '0;
      pm_q      <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      last_hr_q <= '0;
      last_mn_q <= '0;
      last_sc_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hr_bcd_q  <= hr_bcd_d;
      mn_bcd_q  <= mn_bcd_d;
      sc_bcd_q  <= sc_bcd_d;
      hr_bin_q  <= hr_bin_d;
      mn_bin_q  <= mn_bin_d;
      sc_bin_q  <= sc_bin_d;
      pm_cap_q  <= pm_cap_d;
      hhmm_q    <= hhmm_d;
      sec_q     <= sec_d;
      pm_q      <= pm_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      last_hr_q <= last_hr_d;
      last_mn_q <= last_mn_d;
      last_sc_q <= last_sc_d;
    end
  end

  assign hhmm_bcd = hhmm_q;
  assign sec_bcd  = sec_q;
  assign pm       = pm_q;
  assign busy     = (state_q != ST_IDLE);
  assign valid    = valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_time_bcd_converter.sv
// Directed bench for time_bcd_converter: scoreboard of expected BCD results
// checked on each valid pulse, plus an auto-start instance.
module tb_time_bcd_converter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic [4:0]  hours, a_hours;
  logic [5:0]  minutes, seconds, a_minutes, a_seconds;
  logic        mode_12h, start, a_mode_12h, a_start;
  logic [15:0] hhmm_bcd, a_hhmm_bcd;
  logic [7:0]  sec_bcd, a_sec_bcd;
  logic        pm, busy, valid, err;
  logic        a_pm, a_busy, a_valid, a_err;

  always #5 clk = ~clk;

  time_bcd_converter #(.AUTO_START(1'b0)) dut (
    .clk(clk), .reset(reset), .hours(hours), .minutes(minutes), .seconds(seconds),
    .mode_12h(mode_12h), .start(start), .hhmm_bcd(hhmm_bcd), .sec_bcd(sec_bcd),
    .pm(pm), .busy(busy), .valid(valid), .err(err)
  );

  time_bcd_converter #(.AUTO_START(1'b1)) dut_auto (
    .clk(clk), .reset(reset), .hours(a_hours), .minutes(a_minutes), .seconds(a_seconds),
    .mode_12h(a_mode_12h), .start(a_start), .hhmm_bcd(a_hhmm_bcd), .sec_bcd(a_sec_bcd),
    .pm(a_pm), .busy(a_busy), .valid(a_valid), .err(a_err)
  );

  typedef struct packed {
    logic [15:0] hhmm;
    logic [7:0]  sec;
    logic        pm;
  } exp_t;

  exp_t        sb[$];
  exp_t        sb_a[$];
  exp_t        last_exp = '0;
  int unsigned total  = 0;
  int unsigned passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bcd8(input int unsigned v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic exp_t model(input int unsigned h, input int unsigned m,
                                 input int unsigned s, input logic m12);
    int unsigned hh = h;
    logic        p  = 1'b0;
    exp_t        e;
    if (m12) begin
      if (h == 0) hh = 12;
      else if (h >= 12) begin
        p = 1'b1;
        if (h > 12) hh = h - 12;
      end
    end
    e.hhmm = {bcd8(hh), bcd8(m)};
    e.sec  = bcd8(s);
    e.pm   = p;
    return e;
  endfunction

  task automatic drive(input int unsigned h, input int unsigned m,
                       input int unsigned s, input logic md);
    hours    = 5'(h);
    minutes  = 6'(m);
    seconds  = 6'(s);
    mode_12h = md;
  endtask

  // n0 = clock edges already elapsed since (and including) the capture edge.
  task automatic wait_result(input string tag, input int n0);
    int   lat = n0;
    int   bc  = n0;
    exp_t e;
    while (!valid && lat < 30) begin
      tick();
      lat++;
      if (busy) bc++;
    end
    check({tag, " valid seen"}, valid, 1);
    check({tag, " latency"}, lat - 1, 7);
    check({tag, " busy cycles"}, bc, 7);
    check({tag, " err with valid"}, err, 0);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, " hhmm"}, hhmm_bcd, e.hhmm);
      check({tag, " sec"}, sec_bcd, e.sec);
      check({tag, " pm"}, pm, e.pm);
      last_exp = e;
    end
    tick();
    check({tag, " valid single pulse"}, valid, 0);
  endtask

  task automatic convert(input string tag, input int unsigned h, input int unsigned m,
                         input int unsigned s, input logic md);
    drive(h, m, s, md);
    sb.push_back(model(h, m, s, md));
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_result(tag, 1);
  endtask

  task automatic auto_step(input string tag, input int unsigned s, input int unsigned exp_n);
    int   n = 0;
    exp_t e;
    a_seconds = 6'(s);
    if (exp_n != 0) sb_a.push_back(model(0, 0, s, 1'b0));
    repeat (14) begin
      tick();
      if (a_valid) begin
        n++;
        if (sb_a.size() != 0) begin
          e = sb_a.pop_front();
          check({tag, " sec"}, a_sec_bcd, e.sec);
        end
      end
    end
    check({tag, " valid count"}, n, exp_n);
  endtask

  task automatic bad_capture(input string tag, input int unsigned h, input int unsigned m,
                             input int unsigned s);
    drive(h, m, s, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " err"}, err, 1);
    check({tag, " no valid"}, valid, 0);
    check({tag, " not busy"}, busy, 0);
    check({tag, " hhmm held"}, hhmm_bcd, last_exp.hhmm);
    check({tag, " sec held"}, sec_bcd, last_exp.sec);
    tick();
    check({tag, " err one cycle"}, err, 0);
    check({tag, " still idle"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    drive(0, 0, 0, 1'b0);
    start      = 1'b0;
    a_hours    = '0;
    a_minutes  = '0;
    a_seconds  = '0;
    a_mode_12h = 1'b0;
    a_start    = 1'b0;

    #2;
    check("reset hhmm", hhmm_bcd, 16'h0000);
    check("reset sec", sec_bcd, 8'h00);
    check("reset flags", {pm, busy, valid, err}, 4'b0000);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    convert("24h 23:59:59", 23, 59, 59, 1'b0);

    // Abort a conversion mid-shift; outputs must clear asynchronously.
    drive(12, 30, 0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("midshift busy", busy, 1);
    reset = 1'b0;
    #1;
    check("abort hhmm", hhmm_bcd, 16'h0000);
    check("abort sec", sec_bcd, 8'h00);
    check("abort flags", {pm, busy, valid, err}, 4'b0000);
    tick();
    reset = 1'b1;
    tick();
    check("post-abort idle", busy, 0);
    last_exp = '0;

    convert("zero", 0, 0, 0, 1'b0);
    convert("12h 0:05", 0, 5, 0, 1'b1);
    convert("12h 12:30", 12, 30, 0, 1'b1);
    convert("12h 13:07", 13, 7, 0, 1'b1);
    convert("12h 11:59", 11, 59, 1, 1'b1);
    convert("24h 13:07", 13, 7, 42, 1'b0);

    bad_capture("minutes 60", 10, 60, 0);
    bad_capture("hours 24", 24, 0, 0);
    bad_capture("seconds 63", 1, 1, 63);

    for (int i = 0; i < 4; i++) begin
      convert("random", $urandom_range(0, 23), $urandom_range(0, 59),
              $urandom_range(0, 59), 1'($urandom_range(0, 1)));
    end

    // start held high: the second capture happens on the edge after valid.
    drive(9, 41, 17, 1'b0);
    sb.push_back(model(9, 41, 17, 1'b0));
    sb.push_back(model(9, 41, 17, 1'b0));
    start = 1'b1;
    tick();
    wait_result("hold first", 1);
    check("hold retrigger busy", busy, 1);
    start = 1'b0;
    wait_result("hold second", 1);

    // A start pulse during a conversion is dropped.
    drive(7, 8, 9, 1'b1);
    sb.push_back(model(7, 8, 9, 1'b1));
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_result("busy start", 4);
    n = 0;
    repeat (12) begin
      tick();
      if (valid) n++;
    end
    check("busy start no extra valid", n, 0);

    auto_step("auto idle", 0, 0);
    auto_step("auto 0->1", 1, 1);
    auto_step("auto 1->2", 2, 1);
    auto_step("auto unchanged", 2, 0);
    check("auto hhmm", a_hhmm_bcd, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
